cla_4b: RTL and testbench

- Carry-look-ahead adder computing a + b + c0 with carry-out.
- Registered output stage in a single clock domain.
- Used as the arithmetic primitive under the Braun multiplier work and as a standalone, verifiable adder.
- Carries are computed from generate/propagate terms, never by rippling.

---
 rtl/cla_pkg.sv | 12 +
 rtl/cla_group4.sv | 38 +++
 rtl/cla_4b.sv | 82 ++++++++
 tb/tb_cla_4b.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants, types and helpers for the carry-look-ahead adder family.
package cla_pkg;

    localparam int unsigned CLA_GROUP = 32'd4;

    typedef logic [CLA_GROUP-1:0] grp_vec_t;

    function automatic int unsigned cla_num_groups(input int unsigned num_bits);
        return num_bits / CLA_GROUP;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// Combinational 4-bit look-ahead slice: flat two-level carries from the slice
// carry-in, plus group generate/propagate for the second-level unit.
module cla_group4
    import cla_pkg::*;
(
    input  grp_vec_t a,
    input  grp_vec_t b,
    input  logic     cin,
    output grp_vec_t sum,
    output logic     g,
    output logic     p,
    output logic     cout
);

    grp_vec_t g_s;
    grp_vec_t p_s;
    grp_vec_t c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Every carry is a single sum-of-products of g/p and cin; nothing ripples.
    assign c_s[0] = cin;
    assign c_s[1] = g_s[0] | (p_s[0] & cin);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & cin);

    assign g    = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0]);
    assign p    = &p_s;
    assign cout = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);

    assign sum  = p_s ^ c_s;

endmodule

// File: rtl/cla_4b.sv
// Registered carry-look-ahead adder: {c_out, sum} = a + b + c0, one cycle latency.
// NUM_BITS must be a positive multiple of 4.
module cla_4b
    import cla_pkg::*;
#(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                c0,
    output logic [NUM_BITS-1:0] sum,
    output logic                c_out
);

    localparam int NUM_GROUPS = int'(cla_num_groups(NUM_BITS));

    logic [NUM_GROUPS-1:0] grp_g_s;
    logic [NUM_GROUPS-1:0] grp_p_s;
    logic [NUM_GROUPS-1:0] grp_cout_s;
    logic [NUM_GROUPS:0]   c_grp_s;
    logic                  carry_s;
    logic                  prod_s;
    logic [NUM_BITS-1:0]   sum_d;
    logic                  c_out_d;
    logic [NUM_BITS-1:0]   sum_q;
    logic                  c_out_q;

    for (genvar j = 0; j < NUM_GROUPS; j++) begin : g_slice
        cla_group4 u_grp (
            .a    (a[j*CLA_GROUP +: CLA_GROUP]),
            .b    (b[j*CLA_GROUP +: CLA_GROUP]),
            .cin  (c_grp_s[j]),
            .sum  (sum_d[j*CLA_GROUP +: CLA_GROUP]),
            .g    (grp_g_s[j]),
            .p    (grp_p_s[j]),
            .cout (grp_cout_s[j])
        );
    end

    // Second-level look-ahead: each group carry is a flat OR of G/P products back to c0.
    always_comb begin
        c_grp_s    = '0;
        c_grp_s[0] = c0;
        carry_s    = 1'b0;
        prod_s     = 1'b0;
        for (int j = 0; j < NUM_GROUPS; j++) begin
            carry_s = 1'b0;
            for (int k = 0; k <= j; k++) begin
                prod_s = grp_g_s[k];
                for (int m = k + 1; m <= j; m++) begin
                    prod_s = prod_s & grp_p_s[m];
                end
                carry_s = carry_s | prod_s;
            end
            prod_s = c0;
            for (int m = 0; m <= j; m++) begin
                prod_s = prod_s & grp_p_s[m];
            end
            c_grp_s[j+1] = carry_s | prod_s;
        end
    end

    // The top slice's own carry-out equals the look-ahead top carry; both feed c_out.
    assign c_out_d = c_grp_s[NUM_GROUPS] | grp_cout_s[NUM_GROUPS-1];

    // Output register; reset drops the in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_cla_4b.sv
// Scoreboard bench for cla_4b: expected {c_out,sum} queued at drive time, popped one cycle later.
module tb_cla_4b;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       c0;
    logic [3:0] sum;
    logic       c_out;

    logic [4:0] exp_q [$];
    logic [4:0] exp_v;
    logic [4:0] got_v;
    int         chk_cnt  = 0;
    int         pass_cnt = 0;

    cla_4b #(.NUM_BITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .c0    (c0),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    // Drive one sample, queue its expected result, and advance to just after the capturing edge.
    task automatic apply(input logic [3:0] va, input logic [3:0] vb, input logic vc, input logic vr);
        a   = va;
        b   = vb;
        c0  = vc;
        rst = vr;
        exp_q.push_back(vr ? 5'd0 : ({1'b0, va} + {1'b0, vb} + {4'd0, vc}));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(4'hF, 4'hF, 1'b1, 1'b1);
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL reset: scoreboard empty");
            end else begin
                exp_v = exp_q.pop_front();
                got_v = {c_out, sum};
                if (got_v !== exp_v) $display("FAIL reset cycle %0d: got %h expected %h", i, got_v, exp_v);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_basic();
        apply(4'd3, 4'd5, 1'b0, 1'b0);
        chk_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL basic: scoreboard empty");
        end else begin
            exp_v = exp_q.pop_front();
            got_v = {c_out, sum};
            if (got_v !== exp_v || got_v !== 5'd8) $display("FAIL basic: got %h expected %h", got_v, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_max_carry();
        apply(4'hF, 4'hF, 1'b1, 1'b0);
        chk_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL max_carry: scoreboard empty");
        end else begin
            exp_v = exp_q.pop_front();
            got_v = {c_out, sum};
            if (got_v !== exp_v || got_v !== 5'h1F) $display("FAIL max_carry: got %h expected %h", got_v, exp_v);
            else pass_cnt++;
        end
    endtask

    task automatic test_full_propagate();
        logic [4:0] fixed [2];
        fixed[0] = 5'b1_0000;
        fixed[1] = 5'b0_1111;
        for (int i = 0; i < 2; i++) begin
            apply(4'b1010, 4'b0101, (i == 0) ? 1'b1 : 1'b0, 1'b0);
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL propagate: scoreboard empty");
            end else begin
                exp_v = exp_q.pop_front();
                got_v = {c_out, sum};
                if (got_v !== exp_v || got_v !== fixed[i])
                    $display("FAIL propagate c0=%0d: got %h expected %h", (i == 0) ? 1 : 0, got_v, fixed[i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic       vc [3];
        logic [4:0] fixed [3];
        va[0] = 4'd1; vb[0] = 4'd1; vc[0] = 1'b0; fixed[0] = 5'b0_0010;
        va[1] = 4'd7; vb[1] = 4'd9; vc[1] = 1'b0; fixed[1] = 5'b1_0000;
        va[2] = 4'd8; vb[2] = 4'd8; vc[2] = 1'b1; fixed[2] = 5'b1_0001;
        for (int i = 0; i < 3; i++) begin
            apply(va[i], vb[i], vc[i], 1'b0);
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL back_to_back: scoreboard empty");
            end else begin
                exp_v = exp_q.pop_front();
                got_v = {c_out, sum};
                if (got_v !== exp_v || got_v !== fixed[i])
                    $display("FAIL back_to_back step %0d: got %h expected %h", i, got_v, fixed[i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_random_reset();
        for (int i = 0; i < 1000; i++) begin
            apply(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
                  (i == 500) ? 1'b1 : 1'b0);
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL random: scoreboard empty");
            end else begin
                exp_v = exp_q.pop_front();
                got_v = {c_out, sum};
                if (got_v !== exp_v)
                    $display("FAIL random #%0d a=%h b=%h c0=%b rst=%b: got %h expected %h",
                             i, a, b, c0, rst, got_v, exp_v);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_exhaustive();
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    apply(4'(ia), 4'(ib), 1'(ic), 1'b0);
                    chk_cnt++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL exhaustive: scoreboard empty");
                    end else begin
                        exp_v = exp_q.pop_front();
                        got_v = {c_out, sum};
                        if (got_v !== exp_v)
                            $display("FAIL exhaustive a=%h b=%h c0=%0d: got %h expected %h",
                                     ia, ib, ic, got_v, exp_v);
                        else pass_cnt++;
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = 4'hF;
        b   = 4'hF;
        c0  = 1'b1;
        test_reset();
        test_basic();
        test_max_carry();
        test_full_propagate();
        test_back_to_back();
        test_random_reset();
        test_exhaustive();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
